// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Purpose  : Shared types for ALU sharing/sequencing logic: op-code enum,
//            controller state encoding, one-hot ALU select bundle and the
//            multiply-class helper.
// Revision : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_MUL    = 4'd2,
    OP_MULH   = 4'd3,
    OP_MULHSU = 4'd4,
    OP_MULHU  = 4'd5,
    OP_AND    = 4'd6,
    OP_OR     = 4'd7,
    OP_SLT    = 4'd8,
    OP_SLTU   = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic sltu;
    logic slt;
    logic op_or;
    logic op_and;
    logic mulhu;
    logic mulhsu;
    logic mulh;
    logic mul;
    logic sub;
    logic add;
  } alu_sel_t;

  // Multiply-class ops need the ALU inputs held for the multi-cycle latency.
  function automatic logic is_mul(alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decoder
// Purpose  : Combinational decode of a 4-bit ALU op code into the ALU's
//            one-hot select bundle. Codes 10-15 raise illegal and leave every
//            select low.
// Ports    : op      in  4  op code (alu_op_e encoding)
//            sel     out    one-hot select bundle (alu_sel_t)
//            illegal out 1  op code has no ALU function
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output alu_sel_t   sel,
  output logic       illegal
);

  always_comb begin
    sel     = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:    sel.add    = 1'b1;
      OP_SUB:    sel.sub    = 1'b1;
      OP_MUL:    sel.mul    = 1'b1;
      OP_MULH:   sel.mulh   = 1'b1;
      OP_MULHSU: sel.mulhsu = 1'b1;
      OP_MULHU:  sel.mulhu  = 1'b1;
      OP_AND:    sel.op_and = 1'b1;
      OP_OR:     sel.op_or  = 1'b1;
      OP_SLT:    sel.slt    = 1'b1;
      OP_SLTU:   sel.sltu   = 1'b1;
      default:   illegal    = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl
// Purpose  : Shares one integer ALU between two requesters. Round-robin
//            arbitration on a valid/ready request channel, op decode onto the
//            ALU one-hot selects, multi-cycle operand hold for multiplies and
//            a valid/ready response channel carrying the requester id.
// Ports    : clk, rst_n                 clock / async active-low reset
//            req_valid/req_ready [1:0]  request handshake, bit i = requester i
//            req_op0/1, req_a0/1, req_b0/1  per-requester op and operands
//            rsp_valid/rsp_ready        response handshake
//            rsp_id/result/zero/err     captured response fields
//            alu_operand_a/b, alu_sel_* drive the external ALU
//            alu_result, alu_zero_flag  sampled from the external ALU
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_operand_a,
  output logic [WIDTH-1:0] alu_operand_b,
  output logic             alu_sel_add,
  output logic             alu_sel_sub,
  output logic             alu_sel_mul,
  output logic             alu_sel_mulh,
  output logic             alu_sel_mulhsu,
  output logic             alu_sel_mulhu,
  output logic             alu_sel_and,
  output logic             alu_sel_or,
  output logic             alu_sel_slt,
  output logic             alu_sel_sltu,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero_flag
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  ctrl_state_e      state, state_nxt;
  logic             rr_prio;      // requester that wins the next tie
  logic             grant_id;
  logic             accept;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       grant_op;
  alu_sel_t         dec_sel, sel;
  logic             dec_illegal;
  logic             in_exec;

  alu_op_decoder u_dec (
    .op      (op_q),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  // Grant selection: sole requester wins, ties go to the round-robin pointer.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = rr_prio;
      default: grant_id = 1'b0;
    endcase
  end

  assign accept   = (state == ST_IDLE) && (|req_valid);
  assign grant_op = grant_id ? req_op1 : req_op0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req_valid)     state_nxt = ST_EXEC;
      ST_EXEC: if (cnt == '0)      state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)      state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_exec   = (state == ST_EXEC);
    req_ready = accept ? (2'b01 << grant_id) : 2'b00;
    rsp_valid = (state == ST_RESP);
    sel       = in_exec ? dec_sel : '0;
  end

  assign alu_operand_a  = in_exec ? a_q : '0;
  assign alu_operand_b  = in_exec ? b_q : '0;
  assign alu_sel_add    = sel.add;
  assign alu_sel_sub    = sel.sub;
  assign alu_sel_mul    = sel.mul;
  assign alu_sel_mulh   = sel.mulh;
  assign alu_sel_mulhsu = sel.mulhsu;
  assign alu_sel_mulhu  = sel.mulhu;
  assign alu_sel_and    = sel.op_and;
  assign alu_sel_or     = sel.op_or;
  assign alu_sel_slt    = sel.slt;
  assign alu_sel_sltu   = sel.sltu;

  // Request capture, hold counter, arbitration pointer and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_prio    <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      cnt        <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        rr_prio <= ~grant_id;
        op_q    <= grant_op;
        a_q     <= grant_id ? req_a1 : req_a0;
        b_q     <= grant_id ? req_b1 : req_b0;
        id_q    <= grant_id;
        // Counter holds remaining EXEC cycles after the current one.
        cnt     <= is_mul(alu_op_e'(grant_op)) ? CNT_W'(MUL_LAT - 1) : '0;
      end else if (in_exec) begin
        if (cnt == '0) begin
          rsp_id     <= id_q;
          // Illegal ops force a clean zero result regardless of the ALU.
          rsp_result <= dec_illegal ? '0 : alu_result;
          rsp_zero   <= dec_illegal ? 1'b1 : alu_zero_flag;
          rsp_err    <= dec_illegal;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_ctrl
// Purpose  : Self-checking bench for alu_share_ctrl with a behavioural ALU
//            attached to the select/operand outputs and a reference model of
//            op results, latency and round-robin grant order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [3:0] req_op0 = '0, req_op1 = '0;
  logic [WIDTH-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_result, alu_operand_a, alu_operand_b, alu_result;
  logic alu_zero_flag;
  logic sel_add, sel_sub, sel_mul, sel_mulh, sel_mulhsu, sel_mulhu;
  logic sel_and, sel_or, sel_slt, sel_sltu;

  int vectors = 0;
  int miscompares = 0;
  bit last_gnt = 1'b1;  // model: last granted requester, so first tie -> 0

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_sel_add(sel_add), .alu_sel_sub(sel_sub), .alu_sel_mul(sel_mul),
    .alu_sel_mulh(sel_mulh), .alu_sel_mulhsu(sel_mulhsu), .alu_sel_mulhu(sel_mulhu),
    .alu_sel_and(sel_and), .alu_sel_or(sel_or), .alu_sel_slt(sel_slt),
    .alu_sel_sltu(sel_sltu),
    .alu_result(alu_result), .alu_zero_flag(alu_zero_flag)
  );

  // Bit n of this vector is the select for op code n.
  wire [9:0] sel_vec = {sel_sltu, sel_slt, sel_or, sel_and, sel_mulhu,
                        sel_mulhsu, sel_mulh, sel_mul, sel_sub, sel_add};

  // Behavioural ALU standing beside the controller.
  wire [63:0] xa_s = {{32{alu_operand_a[31]}}, alu_operand_a};
  wire [63:0] xb_s = {{32{alu_operand_b[31]}}, alu_operand_b};
  wire [63:0] xb_u = {32'b0, alu_operand_b};
  wire [63:0] xa_u = {32'b0, alu_operand_a};
  wire [63:0] p_ss = xa_s * xb_s;
  wire [63:0] p_su = xa_s * xb_u;
  wire [63:0] p_uu = xa_u * xb_u;

  always_comb begin
    alu_result = '0;
    if (sel_add)    alu_result = alu_operand_a + alu_operand_b;
    if (sel_sub)    alu_result = alu_operand_a - alu_operand_b;
    if (sel_mul)    alu_result = p_uu[31:0];
    if (sel_mulh)   alu_result = p_ss[63:32];
    if (sel_mulhsu) alu_result = p_su[63:32];
    if (sel_mulhu)  alu_result = p_uu[63:32];
    if (sel_and)    alu_result = alu_operand_a & alu_operand_b;
    if (sel_or)     alu_result = alu_operand_a | alu_operand_b;
    if (sel_slt)    alu_result = {31'b0, $signed(alu_operand_a) < $signed(alu_operand_b)};
    if (sel_sltu)   alu_result = {31'b0, alu_operand_a < alu_operand_b};
    alu_zero_flag = (alu_result == '0);
  end

  // Reference result of an op, from the op-code table with plain arithmetic.
  function automatic logic [31:0] ref_result(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, p;
    logic [63:0] uu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    uu = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: begin p = sa * sb; return p[31:0]; end
      4'd3: begin p = sa * sb; return p[63:32]; end
      4'd4: begin p = sa * ua * 0 + sa * longint'({32'b0, b}); return p[63:32]; end
      4'd5: return uu[63:32];
      4'd6: return a & b;
      4'd7: return a | b;
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction, entered 1ns after a rising edge with the DUT idle.
  // Leaves req_valid asserted; returns 1ns after the response handshake edge.
  task automatic txn(logic [1:0] mask,
                     logic [3:0] op0, logic [31:0] a0, logic [31:0] b0,
                     logic [3:0] op1, logic [31:0] a1, logic [31:0] b1, int bp);
    bit g, ill;
    logic [3:0] op;
    logic [31:0] a, b, res;
    int lat;
    g   = (mask == 2'b11) ? ~last_gnt : mask[1];
    op  = g ? op1 : op0;
    a   = g ? a1 : a0;
    b   = g ? b1 : b0;
    ill = (op > 4'd9);
    lat = (op >= 4'd2 && op <= 4'd5) ? MUL_LAT : 1;
    res = ref_result(op, a, b);
    req_valid = mask;
    req_op0 = op0; req_a0 = a0; req_b0 = b0;
    req_op1 = op1; req_a1 = a1; req_b1 = b1;
    #1;
    check("req_ready_grant", 64'(req_ready), 64'(2'b01 << g));
    check("sel_idle", 64'(sel_vec), 64'd0);
    @(posedge clk);
    last_gnt = g;
    #1;
    for (int k = 0; k < lat; k++) begin
      check("sel_exec", 64'(sel_vec), ill ? 64'd0 : 64'(10'b1 << op));
      check("operand_a", 64'(alu_operand_a), 64'(a));
      check("operand_b", 64'(alu_operand_b), 64'(b));
      check("req_ready_exec", 64'(req_ready), 64'd0);
      check("rsp_valid_exec", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k <= bp; k++) begin
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_id", 64'(rsp_id), 64'(g));
      check("rsp_result", 64'(rsp_result), 64'(res));
      check("rsp_zero", 64'(rsp_zero), ill ? 64'd1 : 64'(res == 32'd0));
      check("rsp_err", 64'(rsp_err), 64'(ill));
      check("req_ready_resp", 64'(req_ready), 64'd0);
      check("sel_resp", 64'(sel_vec), 64'd0);
      rsp_ready = (k == bp);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;
    check("rsp_valid_after", 64'(rsp_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    check({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    check({tag, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_opa"}, 64'(alu_operand_a), 64'd0);
    check({tag, "_opb"}, 64'(alu_operand_b), 64'd0);
    check({tag, "_sel"}, 64'(sel_vec), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    // Single ADD from requester 0
    txn(2'b01, 4'd0, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 0);
    req_valid = 2'b00;

    // MULH from requester 1: 0x8000_0000 * 2 -> upper word all ones
    txn(2'b10, 4'd0, 32'd0, 32'd0, 4'd3, 32'h8000_0000, 32'd2, 0);

    // Both valid continuously: grants alternate 0,1,0,1, all zero results
    for (int i = 0; i < 4; i++)
      txn(2'b11, 4'd1, 32'd3, 32'd3, 4'd7, 32'd0, 32'd0, 0);

    // SLTU 1<2 held under 5 cycles of backpressure, other requester waiting
    txn(2'b11, 4'd9, 32'd1, 32'd2, 4'd0, 32'd9, 32'd9, 5);
    req_valid = 2'b00;

    // Illegal op code 12
    txn(2'b10, 4'd0, 32'd0, 32'd0, 4'd12, 32'h1234, 32'h5678, 1);

    // Reset asserted mid-MUL: immediate abort, pointer back to requester 0
    req_valid = 2'b01; req_op0 = 4'd2; req_a0 = 32'd6; req_b0 = 32'd7;
    @(posedge clk); #1;
    last_gnt = 1'b0;
    check("mul_exec_sel", 64'(sel_vec), 64'(10'b100));
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("no_rsp_after_abort", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
    end
    txn(2'b11, 4'd6, 32'hF0F0, 32'h0FF0, 4'd8, 32'hFFFF_FFFF, 32'd1, 0);
    req_valid = 2'b00;

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0] m;
      logic [31:0] ra0, rb0, ra1, rb1;
      m   = 2'($urandom_range(1, 3));
      ra0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      txn(m, 4'($urandom_range(0, 15)), ra0, rb0,
             4'($urandom_range(0, 15)), ra1, rb1, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) req_valid = 2'b00;
    end
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
